// File: rtl/muldiv_pkg.sv
// Shared state encoding, defaults and output bundle for the multiply/divide scheduler.
package muldiv_pkg;

  localparam int unsigned MULT_CYCLES_DEF = 33;
  localparam int unsigned DIV_TIMEOUT_DEF = 40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    M_START = 3'd1,
    M_WAIT  = 3'd2,
    D_START = 3'd3,
    D_WAIT  = 3'd4,
    WRITE   = 3'd5,
    ABORT   = 3'd6
  } state_e;

  // Control outputs towards the datapath, kept together so they register as one word.
  typedef struct packed {
    logic mult_ctrl;
    logic div_ctrl;
    logic diva_sel;
    logic divb_sel;
    logic md_sel;
    logic hi_ctrl;
    logic lo_ctrl;
    logic busy;
    logic done;
    logic dz_excpt;
    logic tmo_err;
  } ctrl_out_t;

endpackage

// File: rtl/md_counter.sv
// Load/decrement down counter with zero flag; saturates at zero instead of wrapping.
module md_counter #(
  parameter int unsigned CW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load has priority, decrement holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_sched.sv
// Sequences the multi-cycle multiplier and the divider and controls the Hi/Lo writes.
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_mult,
  input  logic start_div,
  input  logic div_src_mdr,
  input  logic div_end,
  input  logic div_zero,
  output logic mult_ctrl,
  output logic div_ctrl,
  output logic DIVASelect,
  output logic DIVBSelect,
  output logic MDSelect,
  output logic HiCtrl,
  output logic LoCtrl,
  output logic busy,
  output logic done,
  output logic dz_excpt,
  output logic tmo_err
);

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_TIMEOUT) ? MULT_CYCLES : DIV_TIMEOUT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e        state_q, state_d;
  logic          src_q, src_d;
  logic          is_mult_q, is_mult_d;
  ctrl_out_t     out_q, out_d;
  logic          cnt_load;
  logic          cnt_dec;
  logic [CW-1:0] cnt_val;
  logic          cnt_zero;
  logic          abort_dz;
  logic          abort_tmo;

  md_counter #(
    .CW(CW)
  ) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Next-state, counter control and next registered outputs.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    is_mult_d = is_mult_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_val   = '0;
    abort_dz  = 1'b0;
    abort_tmo = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_mult) begin
          state_d   = M_START;
          is_mult_d = 1'b1;
          src_d     = 1'b0;
        end else if (start_div) begin
          state_d   = D_START;
          is_mult_d = 1'b0;
          src_d     = div_src_mdr;
        end
      end
      M_START: begin
        cnt_load = 1'b1;
        cnt_val  = CW'(MULT_CYCLES - 1);
        state_d  = M_WAIT;
      end
      M_WAIT: begin
        if (cnt_zero) begin
          state_d = WRITE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      D_START: begin
        cnt_load = 1'b1;
        cnt_val  = CW'(DIV_TIMEOUT - 1);
        state_d  = D_WAIT;
      end
      D_WAIT: begin
        // Divide-by-zero beats completion, completion beats timeout.
        if (div_zero) begin
          state_d  = ABORT;
          abort_dz = 1'b1;
        end else if (div_end) begin
          state_d = WRITE;
        end else if (cnt_zero) begin
          state_d   = ABORT;
          abort_tmo = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      WRITE:   state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are a function of the next state so they register alongside it.
    out_d           = '0;
    out_d.busy      = (state_d != IDLE);
    out_d.mult_ctrl = (state_d == M_START);
    out_d.div_ctrl  = (state_d == D_START);
    out_d.diva_sel  = (state_d != IDLE) && src_d;
    out_d.divb_sel  = (state_d != IDLE) && src_d;
    out_d.md_sel    = (state_d == WRITE) && is_mult_d;
    out_d.hi_ctrl   = (state_d == WRITE);
    out_d.lo_ctrl   = (state_d == WRITE);
    out_d.done      = (state_d == WRITE);
    out_d.dz_excpt  = abort_dz;
    out_d.tmo_err   = abort_tmo;
  end

  // State, operand-source latch and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      src_q     <= 1'b0;
      is_mult_q <= 1'b0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      is_mult_q <= is_mult_d;
      out_q     <= out_d;
    end
  end

  assign mult_ctrl  = out_q.mult_ctrl;
  assign div_ctrl   = out_q.div_ctrl;
  assign DIVASelect = out_q.diva_sel;
  assign DIVBSelect = out_q.divb_sel;
  assign MDSelect   = out_q.md_sel;
  assign HiCtrl     = out_q.hi_ctrl;
  assign LoCtrl     = out_q.lo_ctrl;
  assign busy       = out_q.busy;
  assign done       = out_q.done;
  assign dz_excpt   = out_q.dz_excpt;
  assign tmo_err    = out_q.tmo_err;

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 Parameter MULT_CYCLES, default 33, the number of cycles the multiplier needs after its start pulse.
REQ-002 Parameter DIV_TIMEOUT, default 40, the maximum number of cycles to wait for div_end before aborting.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start_mult  in  1  one-cycle request from control unit to run a multiply.
REQ-006 start_div  in  1  one-cycle request from control unit to run a divide.
REQ-007 div_src_mdr  in  1  operand source for the divide: 0 = A/B registers, 1 = MDR; sampled together with start_div.
REQ-008 div_end  in  1  divider completion flag.
REQ-009 div_zero  in  1  divider divide-by-zero flag (DIVQ).
REQ-010 mult_ctrl  out  1  multiplier start pulse.
REQ-011 div_ctrl  out  1  divider start pulse.
REQ-012 DIVASelect, DIVBSelect  out  1 each  divider operand mux selects.
REQ-013 MDSelect  out  1  Hi/Lo source select: 1 = multiplier, 0 = divider.
REQ-014 HiCtrl, LoCtrl  out  1 each  Hi and Lo register write enables.
REQ-015 busy  out  1  an operation is in progress.
REQ-016 done  out  1  one-cycle pulse: result written to Hi/Lo.
REQ-017 dz_excpt  out  1  one-cycle pulse: divide-by-zero, Hi/Lo not written.
REQ-018 tmo_err  out  1  one-cycle pulse: divide timeout, Hi/Lo not written.

Function
REQ-019 The FSM states SHALL be IDLE, M_START, M_WAIT, D_START, D_WAIT, WRITE and ABORT.
REQ-020 IDLE: on start_mult -> M_START; else on start_div -> D_START, latching div_src_mdr; simultaneous requests: multiply wins, start_div dropped.
REQ-021 Starts in any non-IDLE state, including WRITE and ABORT, SHALL be ignored with no queuing.
REQ-022 M_START lasts 1 cycle with mult_ctrl=1, loads counter with MULT_CYCLES-1 and goes to M_WAIT.
REQ-023 M_WAIT lasts exactly MULT_CYCLES cycles: decrement, and at counter==0 go to WRITE with MDSelect=1.
REQ-024 D_START lasts 1 cycle with div_ctrl=1, loads counter with DIV_TIMEOUT-1 and goes to D_WAIT.
REQ-025 DIVASelect=DIVBSelect=latched div_src_mdr from D_START through WRITE/ABORT; 0 otherwise.
REQ-026 D_WAIT: div_zero -> ABORT (dz); else div_end -> WRITE with MDSelect=0; else at counter==0 -> ABORT (tmo); else decrement.
REQ-027 In D_WAIT, div_zero SHALL take precedence over div_end, and div_end over timeout, when they occur in the same cycle.
REQ-028 WRITE lasts 1 cycle: HiCtrl=LoCtrl=done=1, MDSelect held, then -> IDLE.
REQ-029 ABORT lasts 1 cycle: exactly one of dz_excpt/tmo_err=1, HiCtrl=LoCtrl=0, then -> IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 Multiply latency: start_mult in cycle 0 gives mult_ctrl in cycle 1 and done in cycle MULT_CYCLES+2; IDLE is reached in cycle MULT_CYCLES+3.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-033 The counter SHALL be wide enough for the larger of MULT_CYCLES and DIV_TIMEOUT and SHALL never wrap below 0.

Reset
REQ-034 reset low SHALL force state IDLE, the counter to 0, latched div_src_mdr to 0, and every output to 0, asynchronously.
REQ-035 Reset mid-operation SHALL abandon the operation with no Hi/Lo write and no done, dz_excpt or tmo_err pulse after release.
REQ-036 After reset deasserts, the first rising edge SHALL already accept a start.

Structure
REQ-037 Package muldiv_pkg SHALL hold the state encoding and the MULT_CYCLES/DIV_TIMEOUT defaults.
REQ-038 One sub-module, md_counter (load/decrement/zero-flag down counter), SHALL serve both the multiply wait and the divide timeout.

Verification
REQ-039 start_mult at cycle 0 -> mult_ctrl=1 in cycle 1, HiCtrl=LoCtrl=MDSelect=done=1 in cycle 35, busy=0 in cycle 36.
REQ-040 start_div with div_src_mdr=1, div_end at D_WAIT cycle 10 -> DIVASelect=DIVBSelect=1 throughout, WRITE with MDSelect=0 the next cycle, one done pulse.
REQ-041 start_div, div_zero and div_end both high in the same cycle -> dz_excpt pulse, HiCtrl=LoCtrl=0, done never asserted.
REQ-042 start_div, no div_end -> tmo_err after 40 D_WAIT cycles, no Hi/Lo write, back to IDLE.
REQ-043 start_mult and start_div simultaneous, then start_div during M_WAIT -> only the multiply runs, div_ctrl never pulses.
REQ-044 reset low during M_WAIT cycle 20 -> all outputs 0 immediately; after release no done, and a new start_div is accepted.
